// File: rtl/maquina_pkg.sv
// Shared types and selector code constants for the gear sequencer.
package maquina_pkg;

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    REV   = 2'd1,
    NEUT  = 2'd2,
    DRIVE = 2'd3
  } mode_t;

  // Selector bit order is {P,R,N,D}, bit0 = D.
  localparam logic [3:0] SEL_P = 4'b1000;
  localparam logic [3:0] SEL_R = 4'b0100;
  localparam logic [3:0] SEL_N = 4'b0010;
  localparam logic [3:0] SEL_D = 4'b0001;

  function automatic logic is_onehot4(input logic [3:0] code);
    return (code != 4'b0000) && ((code & (code - 4'b0001)) == 4'b0000);
  endfunction

  function automatic mode_t code_to_mode(input logic [3:0] code);
    case (code)
      SEL_R:   return REV;
      SEL_N:   return NEUT;
      SEL_D:   return DRIVE;
      default: return PARK;
    endcase
  endfunction

endpackage

// File: rtl/maquina_sel_debounce.sv
// Two-flop synchroniser on the raw selector plus a stability counter; a code is
// accepted once DEBOUNCE_CYCLES consecutive synchronised samples agree.
module maquina_sel_debounce
  import maquina_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sel,
  output logic [3:0] code,
  output logic       valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // sync1 is the sample entering sync2 on this edge; a change restarts the run at one.
  always_comb begin
    cnt_next = cnt;
    if (sync1 != sync2) begin
      cnt_next = CW'(1);
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= SEL_P;
      sync2 <= SEL_P;
      cnt   <= '0;
      code  <= SEL_P;
      valid <= 1'b1;
    end else begin
      sync1 <= sel;
      sync2 <= sync1;
      cnt   <= cnt_next;
      if (cnt_next == CNT_MAX) begin
        code  <= sync1;
        valid <= is_onehot4(sync1);
      end
    end
  end

endmodule

// File: rtl/maquina_gear_sequencer.sv
// Selector-driven mode FSM with reverse/drive neutral interlock, dwell-timed
// auto-upshift and kickdown across N_GEARS forward gears.
module maquina_gear_sequencer
  import maquina_pkg::*;
#(
  parameter int N_GEARS         = 4,
  parameter int DWELL_CYCLES    = 1000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         sel,
  input  logic               kick,
  output logic [N_GEARS-1:0] gear_oh,
  output logic               park,
  output logic               neutral,
  output logic               reverse,
  output logic               shift,
  output logic               fault
);

  localparam int GW = $clog2(N_GEARS);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [GW-1:0] GEAR_TOP   = GW'(N_GEARS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  logic [3:0]    code;
  logic          valid;
  mode_t         mode;
  mode_t         mode_next;
  mode_t         target;
  logic [GW-1:0] gear;
  logic [GW-1:0] gear_next;
  logic [DW-1:0] dwell;
  logic [DW-1:0] dwell_next;
  logic          shift_next;

  maquina_sel_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .code (code),
    .valid(valid)
  );

  // An invalid accepted code freezes mode, gear and dwell entirely.
  always_comb begin
    mode_next  = mode;
    gear_next  = gear;
    dwell_next = dwell;
    shift_next = 1'b0;
    target     = code_to_mode(code);
    if (valid) begin
      if (target == mode) begin
        if (mode == DRIVE) begin
          if (kick && (gear != '0)) begin
            gear_next  = gear - GW'(1);
            dwell_next = '0;
            shift_next = 1'b1;
          end else if (gear == GEAR_TOP) begin
            dwell_next = '0;
          end else if (dwell == DWELL_LAST) begin
            gear_next  = gear + GW'(1);
            dwell_next = '0;
            shift_next = 1'b1;
          end else begin
            dwell_next = dwell + DW'(1);
          end
        end
      end else begin
        gear_next  = '0;
        dwell_next = '0;
        // Reverse and drive never meet directly; NEUT sits between them for one cycle.
        if ((mode == REV && target == DRIVE) || (mode == DRIVE && target == REV)) begin
          mode_next = NEUT;
        end else begin
          mode_next = target;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode    <= PARK;
      gear    <= '0;
      dwell   <= '0;
      gear_oh <= '0;
      park    <= 1'b1;
      neutral <= 1'b0;
      reverse <= 1'b0;
      shift   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      mode    <= mode_next;
      gear    <= gear_next;
      dwell   <= dwell_next;
      gear_oh <= (mode_next == DRIVE) ? (N_GEARS'(1) << gear_next) : '0;
      park    <= (mode_next == PARK);
      neutral <= (mode_next == NEUT);
      reverse <= (mode_next == REV);
      shift   <= shift_next;
      fault   <= !valid;
    end
  end

endmodule

// File: tb/tb_maquina_gear_sequencer.sv
// Directed scenarios plus randomized selector/kick traffic, checked every cycle
// against a behavioural model of the sequencer.
module tb_maquina_gear_sequencer;

  localparam int N_GEARS  = 4;
  localparam int DWELL    = 8;
  localparam int DEBOUNCE = 4;

  logic       clk;
  logic       reset;
  logic [3:0] sel;
  logic       kick;
  logic [3:0] gear_oh;
  logic       park;
  logic       neutral;
  logic       reverse;
  logic       shift;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state: mode 0=P 1=R 2=N 3=D
  int         m_mode  = 0;
  int         m_gear  = 0;
  int         m_dwell = 0;
  bit         m_shift = 0;
  bit         m_fault = 0;
  logic [3:0] m_s1    = 4'b1000;
  logic [3:0] m_s2    = 4'b1000;
  logic [3:0] m_acc   = 4'b1000;
  logic [3:0] win[$];

  maquina_gear_sequencer #(
    .N_GEARS        (N_GEARS),
    .DWELL_CYCLES   (DWELL),
    .DEBOUNCE_CYCLES(DEBOUNCE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .kick   (kick),
    .gear_oh(gear_oh),
    .park   (park),
    .neutral(neutral),
    .reverse(reverse),
    .shift  (shift),
    .fault  (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int code_mode(input logic [3:0] c);
    case (c)
      4'b1000: return 0;
      4'b0100: return 1;
      4'b0010: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_edge();
    int  tgt;
    bit  same;
    if (!reset) begin
      m_mode = 0; m_gear = 0; m_dwell = 0; m_shift = 0; m_fault = 0;
      m_s1 = 4'b1000; m_s2 = 4'b1000; m_acc = 4'b1000;
      win.delete();
    end else begin
      m_shift = 0;
      if ($countones(m_acc) != 1) begin
        m_fault = 1;
      end else begin
        m_fault = 0;
        tgt = code_mode(m_acc);
        if (tgt == m_mode) begin
          if (m_mode == 3) begin
            if (kick && m_gear > 0) begin
              m_gear--; m_dwell = 0; m_shift = 1;
            end else if (m_gear == N_GEARS - 1) begin
              m_dwell = 0;
            end else if (m_dwell == DWELL - 1) begin
              m_gear++; m_dwell = 0; m_shift = 1;
            end else begin
              m_dwell++;
            end
          end
        end else begin
          m_gear = 0;
          m_dwell = 0;
          if ((m_mode == 1 && tgt == 3) || (m_mode == 3 && tgt == 1)) m_mode = 2;
          else m_mode = tgt;
        end
      end
      m_s2 = m_s1;
      m_s1 = sel;
      win.push_back(m_s2);
      if (win.size() > DEBOUNCE) win.delete(0);
      if (win.size() == DEBOUNCE) begin
        same = 1;
        foreach (win[i]) if (win[i] !== m_s2) same = 0;
        if (same) m_acc = m_s2;
      end
    end
  endtask

  function automatic logic [8:0] model_outs();
    logic [3:0] g;
    g = (m_mode == 3) ? 4'(1 << m_gear) : 4'b0000;
    return {g, m_mode == 0, m_mode == 2, m_mode == 1, m_shift, m_fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_eq("outs", {gear_oh, park, neutral, reverse, shift, fault}, model_outs());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hold;
    reset = 1'b0;
    sel   = 4'b1000;
    kick  = 1'b0;
    ticks(2);
    reset = 1'b1;
    ticks(1);
    check_eq("rst_park", park, 1);
    check_eq("rst_gear", gear_oh, 0);
    check_eq("rst_fault", fault, 0);

    sel = 4'b0001;
    ticks(5);
    check_eq("d_lat5", park, 1);
    ticks(1);
    check_eq("d_enter", gear_oh, 4'b0001);
    check_eq("d_park_off", park, 0);
    for (int g = 1; g < N_GEARS; g++) begin
      ticks(DWELL - 1);
      check_eq("pre_up", gear_oh, 1 << (g - 1));
      ticks(1);
      check_eq("up", gear_oh, 1 << g);
      check_eq("up_pulse", shift, 1);
    end
    ticks(1);
    check_eq("pulse_end", shift, 0);
    ticks(15);
    check_eq("top_hold", gear_oh, 4'b1000);
    check_eq("top_noshift", shift, 0);

    sel = 4'b0100;
    ticks(6);
    check_eq("d2r_neut", neutral, 1);
    check_eq("d2r_gear0", gear_oh, 0);
    ticks(1);
    check_eq("d2r_rev", reverse, 1);
    sel = 4'b0001;
    ticks(6);
    check_eq("r2d_neut", neutral, 1);
    ticks(1);
    check_eq("r2d_drive", gear_oh, 4'b0001);

    for (int i = 0; i < 20; i++) begin
      sel = (((i / 2) % 2) == 0) ? 4'b0010 : 4'b0001;
      ticks(1);
    end
    check_eq("bounce_neut", neutral, 0);
    sel = 4'b0010;
    ticks(5);
    check_eq("bounce_lat5", neutral, 0);
    ticks(1);
    check_eq("bounce_neut6", neutral, 1);

    sel = 4'b0001;
    ticks(6);
    check_eq("f_drive", gear_oh, 4'b0001);
    ticks(3);
    sel = 4'b0011;
    ticks(5);
    check_eq("fault_lat5", fault, 0);
    ticks(1);
    check_eq("fault_set", fault, 1);
    check_eq("fault_gear", gear_oh, 4'b0010);
    ticks(10);
    check_eq("fault_hold", fault, 1);
    check_eq("fault_gear_hold", gear_oh, 4'b0010);
    sel = 4'b0001;
    ticks(6);
    check_eq("fault_clr", fault, 0);
    check_eq("resume_gear", gear_oh, 4'b0010);

    ticks(14);
    check_eq("kick_pre", gear_oh, 4'b0100);
    kick = 1'b1;
    ticks(1);
    kick = 1'b0;
    check_eq("kick_due", gear_oh, 4'b0010);
    check_eq("kick_pulse", shift, 1);
    ticks(1);
    check_eq("kick_single", shift, 0);
    ticks(6);
    check_eq("kick_dwell0", gear_oh, 4'b0010);
    ticks(1);
    check_eq("kick_reup", gear_oh, 4'b0100);

    kick = 1'b1;
    ticks(1);
    check_eq("kick_b2b_1", gear_oh, 4'b0010);
    ticks(1);
    check_eq("kick_b2b_2", gear_oh, 4'b0001);
    check_eq("kick_b2b_pulse", shift, 1);
    ticks(1);
    check_eq("kick_g0", gear_oh, 4'b0001);
    check_eq("kick_g0_noshift", shift, 0);
    kick = 1'b0;

    reset = 1'b0;
    ticks(1);
    check_eq("rst_mid_park", park, 1);
    check_eq("rst_mid_gear", gear_oh, 0);
    reset = 1'b1;

    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1:    sel = 4'b1000;
          2:       sel = 4'b0100;
          3, 4:    sel = 4'b0010;
          5, 6, 7: sel = 4'b0001;
          default: sel = 4'($urandom_range(0, 15));
        endcase
        hold = $urandom_range(1, 20);
      end
      hold--;
      kick  = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 399) != 0);
      ticks(1);
    end
    reset = 1'b1;
    kick  = 1'b0;
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
